// File: rtl/me_request_sequencer_pkg.sv
// rtl/me_request_sequencer_pkg.sv - shared widths and FSM state encoding for the ME request sequencer
package me_request_sequencer_pkg;
  localparam int POS_W  = 6;
  localparam int SAD_W  = 16;
  localparam int DIFF_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_FLUSH,
    ST_ERR
  } state_t;
endpackage

// File: rtl/me_request_sequencer_pos_counter.sv
// rtl/me_request_sequencer_pos_counter.sv - 2-D search position walker, h inner, w outer, modulo-64 wrap
module me_request_sequencer_pos_counter
  import me_request_sequencer_pkg::*;
#(
  parameter int GRID_H = 4,
  parameter int GRID_W = 4,
  parameter int STEP   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [POS_W-1:0] origin_h,
  input  logic [POS_W-1:0] origin_w,
  output logic [POS_W-1:0] pos_h,
  output logic [POS_W-1:0] pos_w,
  output logic             last
);
  localparam int HW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int WW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam logic [POS_W-1:0] STEP_P = POS_W'(STEP);

  logic [HW-1:0]    h_idx;
  logic [WW-1:0]    w_idx;
  logic [POS_W-1:0] base_h;
  logic             h_last;
  logic             w_last;

  assign h_last = (h_idx == HW'(GRID_H - 1));
  assign w_last = (w_idx == WW'(GRID_W - 1));
  assign last   = h_last && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_idx  <= '0;
      w_idx  <= '0;
      base_h <= '0;
      pos_h  <= '0;
      pos_w  <= '0;
    end else if (load) begin
      h_idx  <= '0;
      w_idx  <= '0;
      base_h <= origin_h;
      pos_h  <= origin_h;
      pos_w  <= origin_w;
    end else if (step) begin
      // column finished: rewind h to the origin row and move one step in w
      if (h_last) begin
        h_idx <= '0;
        pos_h <= base_h;
        w_idx <= w_idx + WW'(1);
        pos_w <= pos_w + STEP_P;
      end else begin
        h_idx <= h_idx + HW'(1);
        pos_h <= pos_h + STEP_P;
      end
    end
  end
endmodule

// File: rtl/me_request_sequencer.sv
// rtl/me_request_sequencer.sv - walks a search grid over a 4-phase req/ack ME handshake, one result per position
module me_request_sequencer
  import me_request_sequencer_pkg::*;
#(
  parameter int GRID_H      = 4,
  parameter int GRID_W      = 4,
  parameter int STEP        = 16,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*POS_W-1:0]  origin,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                req,
  output logic [2*POS_W-1:0]  init_pos,
  input  logic                ack,
  input  logic [SAD_W-1:0]    min_sad,
  input  logic [2*DIFF_W-1:0] min_diff,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*POS_W-1:0]  res_pos,
  output logic [SAD_W-1:0]    res_sad,
  output logic [2*DIFF_W-1:0] res_mv
);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  state_t           state;
  state_t           state_nx;
  logic [TW-1:0]    tcnt;
  logic             tcnt_run;
  logic             timed_out;
  logic             load;
  logic             step;
  logic             capture;
  logic             done_nx;
  logic             slot_free;
  logic             last;
  logic [POS_W-1:0] pos_h;
  logic [POS_W-1:0] pos_w;

  me_request_sequencer_pos_counter #(
    .GRID_H(GRID_H),
    .GRID_W(GRID_W),
    .STEP  (STEP)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .origin_h(origin[POS_W-1:0]),
    .origin_w(origin[2*POS_W-1:POS_W]),
    .pos_h   (pos_h),
    .pos_w   (pos_w),
    .last    (last)
  );

  assign init_pos  = {pos_w, pos_h};
  assign req       = (state == ST_REQ);
  assign busy      = (state == ST_REQ) || (state == ST_REL) || (state == ST_FLUSH);
  assign slot_free = !res_valid || res_ready;
  assign timed_out = (ACK_TIMEOUT != 0) && (tcnt == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    capture  = 1'b0;
    tcnt_run = 1'b0;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack && slot_free) begin
          capture  = 1'b1;
          state_nx = ST_REL;
        end else if (timed_out) begin
          state_nx = ST_ERR;
        end else begin
          tcnt_run = 1'b1;
        end
      end
      ST_REL: begin
        // the timeout only guards the ack falling edge; a stalled result slot may wait forever
        if (!ack) begin
          if (last) begin
            state_nx = ST_FLUSH;
          end else if (slot_free) begin
            step     = 1'b1;
            state_nx = ST_REQ;
          end
        end else if (timed_out) begin
          state_nx = ST_ERR;
        end else begin
          tcnt_run = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (slot_free) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (state_nx != state) begin
        tcnt <= '0;
      end else if (tcnt_run) begin
        tcnt <= tcnt + TW'(1);
      end
      if (state_nx == ST_ERR) begin
        err <= 1'b1;
      end else if (load) begin
        err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_pos   <= '0;
      res_sad   <= '0;
      res_mv    <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_pos   <= init_pos;
      res_sad   <= min_sad;
      res_mv    <= min_diff;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule
